// File: rtl/argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module      : argmax_classifier
// Description : Final stage of the MNIST inference pipeline. Captures the
//               OUTPUT_SIZE signed logits written by the output layer, then
//               scans them one per cycle to find the index and value of the
//               largest logit. Ties resolve to the lowest index.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   system clock, rising edge
//   rst              in   asynchronous active-high reset
//   start            in   level start, shared with the output layer
//   in_write_en      in   logit write strobe
//   in_write_address in   logit index
//   in_write_data    in   signed logit value
//   done             out  classification complete, held while start is high
//   pred_class       out  index of the maximum logit
//   pred_score       out  value of the maximum logit
//   addr_error       out  sticky: out-of-range write address seen this run
// ============================================================================
module argmax_classifier #(
  parameter int OUTPUT_SIZE  = 10,
  parameter int OUTPUT_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            in_write_en,
  input  logic [$clog2(OUTPUT_SIZE)-1:0]  in_write_address,
  input  logic signed [OUTPUT_WIDTH-1:0]  in_write_data,
  output logic                            done,
  output logic [$clog2(OUTPUT_SIZE)-1:0]  pred_class,
  output logic signed [OUTPUT_WIDTH-1:0]  pred_score,
  output logic                            addr_error
);

  localparam int AW = $clog2(OUTPUT_SIZE);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_COLLECT = 2'd1;
  localparam logic [1:0] c_RESOLVE = 2'd2;
  localparam logic [1:0] c_DONE    = 2'd3;

  localparam logic [AW-1:0] c_LAST_IDX = AW'(OUTPUT_SIZE - 1);
  localparam logic [AW:0]   c_SIZE     = (AW + 1)'(OUTPUT_SIZE);

  logic [1:0]                     r_state;
  logic signed [OUTPUT_WIDTH-1:0] r_store [OUTPUT_SIZE];
  logic [OUTPUT_SIZE-1:0]         r_seen;
  logic [AW-1:0]                  r_idx;
  logic [AW-1:0]                  r_best_idx;
  logic signed [OUTPUT_WIDTH-1:0] r_best;
  logic                           r_done;
  logic [AW-1:0]                  r_pred_class;
  logic signed [OUTPUT_WIDTH-1:0] r_pred_score;
  logic                           r_addr_error;

  logic                           w_addr_ok;
  logic                           w_full;
  logic signed [OUTPUT_WIDTH-1:0] w_cand;
  logic                           w_gt;

  // One extra bit on the address so the range check also works when
  // OUTPUT_SIZE is an exact power of two.
  assign w_addr_ok = ({1'b0, in_write_address} < c_SIZE);
  assign w_full    = &r_seen;

  // Scan candidate; strict compare keeps the earliest index on ties.
  assign w_cand = r_store[r_idx];
  assign w_gt   = (w_cand > r_best);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_seen       <= '0;
      r_idx        <= '0;
      r_best_idx   <= '0;
      r_best       <= '0;
      r_done       <= 1'b0;
      r_pred_class <= '0;
      r_pred_score <= '0;
      r_addr_error <= 1'b0;
      for (int i = 0; i < OUTPUT_SIZE; i++) begin
        r_store[i] <= '0;
      end
    end else begin
      case (r_state)
        c_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state      <= c_COLLECT;
            r_seen       <= '0;
            r_addr_error <= 1'b0;
          end
        end

        c_COLLECT: begin
          // Once every logit has arrived the run is committed: the scan
          // begins on the next edge regardless of start, and any further
          // writes are ignored.
          if (w_full) begin
            r_state    <= c_RESOLVE;
            r_best     <= r_store[0];
            r_best_idx <= '0;
            r_idx      <= AW'(1);
          end else if (!start) begin
            // Abort: previous prediction is left untouched.
            r_state <= c_IDLE;
          end else if (in_write_en) begin
            if (w_addr_ok) begin
              r_store[in_write_address] <= in_write_data;
              r_seen[in_write_address]  <= 1'b1;
            end else begin
              r_addr_error <= 1'b1;
            end
          end
        end

        c_RESOLVE: begin
          if (w_gt) begin
            r_best     <= w_cand;
            r_best_idx <= r_idx;
          end
          if (r_idx == c_LAST_IDX) begin
            // Final compare folds straight into the published result.
            r_pred_class <= w_gt ? r_idx  : r_best_idx;
            r_pred_score <= w_gt ? w_cand : r_best;
            r_done       <= 1'b1;
            r_state      <= c_DONE;
          end else begin
            r_idx <= r_idx + AW'(1);
          end
        end

        c_DONE: begin
          if (!start) begin
            r_done  <= 1'b0;
            r_state <= c_IDLE;
          end
        end

        default: begin
          r_done  <= 1'b0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign done       = r_done;
  assign pred_class = r_pred_class;
  assign pred_score = r_pred_score;
  assign addr_error = r_addr_error;

endmodule
`default_nettype wire

// File: tb/tb_argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_argmax_classifier
// Description : Self-checking bench for argmax_classifier. A run-level
//               reference model tracks collected logits and computes the
//               expected prediction with a plain argmax loop; a compare
//               process checks all outputs every cycle. Directed runs pin
//               the model with hand-computed results, then randomized runs
//               follow.
// Revision    : 1.0  initial release
// ============================================================================
module tb_argmax_classifier;

  localparam int N  = 10;
  localparam int W  = 32;
  localparam int AW = $clog2(N);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  in_write_en;
  logic [AW-1:0]         in_write_address;
  logic signed [W-1:0]   in_write_data;
  logic                  done;
  logic [AW-1:0]         pred_class;
  logic signed [W-1:0]   pred_score;
  logic                  addr_error;

  argmax_classifier #(.OUTPUT_SIZE(N), .OUTPUT_WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .in_write_en      (in_write_en),
    .in_write_address (in_write_address),
    .in_write_data    (in_write_data),
    .done             (done),
    .pred_class       (pred_class),
    .pred_score       (pred_score),
    .addr_error       (addr_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: run bookkeeping at the level of "which logits have been
  // collected" and "when is the answer due"; the answer itself is a plain
  // argmax over the collected values.
  // --------------------------------------------------------------------------
  int m_vals [N];
  bit m_seen [N];
  bit m_collecting = 1'b0;
  int m_due        = -1;
  int m_cyc        = 0;
  bit m_done       = 1'b0;
  int m_class      = 0;
  int m_score      = 0;
  bit m_err        = 1'b0;

  function automatic bit all_seen();
    for (int i = 0; i < N; i++) if (!m_seen[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_collecting = 1'b0;
      m_due        = -1;
      m_done       = 1'b0;
      m_class      = 0;
      m_score      = 0;
      m_err        = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_vals[i] = 0;
        m_seen[i] = 1'b0;
      end
    end else begin
      m_cyc++;
      if (m_done) begin
        if (!start) m_done = 1'b0;
      end else if (m_due >= 0) begin
        if (m_cyc == m_due) begin
          m_class = 0;
          m_score = m_vals[0];
          for (int i = 1; i < N; i++) begin
            if (m_vals[i] > m_score) begin
              m_score = m_vals[i];
              m_class = i;
            end
          end
          m_done = 1'b1;
          m_due  = -1;
        end
      end else if (m_collecting) begin
        if (!start) begin
          m_collecting = 1'b0;
        end else if (in_write_en) begin
          if (int'(in_write_address) < N) begin
            m_vals[in_write_address] = in_write_data;
            m_seen[in_write_address] = 1'b1;
            if (all_seen()) begin
              m_collecting = 1'b0;
              m_due        = m_cyc + N;   // answer N edges after last logit
            end
          end else begin
            m_err = 1'b1;
          end
        end
      end else if (start) begin
        m_collecting = 1'b1;
        m_err        = 1'b0;
        for (int i = 0; i < N; i++) m_seen[i] = 1'b0;
      end
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("done",       int'(done),       int'(m_done));
      check("pred_class", int'(pred_class), m_class);
      check("pred_score", int'(pred_score), m_score);
      check("addr_error", int'(addr_error), int'(m_err));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    in_write_en      = 1'b1;
    in_write_address = AW'(a);
    in_write_data    = d;
    step();
    in_write_en      = 1'b0;
  endtask

  task automatic begin_run();
    start = 1'b1;
    step();
  endtask

  task automatic write_vec(input int v [N]);
    for (int i = 0; i < N; i++) wr(i, v[i]);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 expected=1 after %0d cycles", lat);
    end
  endtask

  task automatic end_run();
    start = 1'b0;
    step();
    step();
  endtask

  function automatic int rval(input int mode);
    int k;
    case (mode)
      0: return int'($urandom);
      1: return int'($urandom_range(0, 6)) - 3;
      default: begin
        k = int'($urandom_range(0, 3));
        if (k == 0) return 32'h8000_0000;
        if (k == 1) return 32'h7fff_ffff;
        if (k == 2) return -1;
        return 0;
      end
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int lat;
    int v1 [N];
    int v2 [N];
    int va [N];
    int vb [N];
    int vr [N];
    int ord [N];
    int tmp, j, mode;
    bit abort;

    v1 = '{5, -3, 12, 7, 0, 1, -8, 2, 11, 4};
    v2 = '{-100, -50, -7, -7, -900, -200, -200, -200, -200, -200};
    va = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    vb = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -1};

    rst = 1'b0; start = 1'b0; in_write_en = 1'b0;
    in_write_address = '0; in_write_data = '0;
    #2 rst = 1'b1;
    repeat (3) step();
    check("reset_done",       int'(done),       0);
    check("reset_pred_class", int'(pred_class), 0);
    check("reset_pred_score", int'(pred_score), 0);
    check("reset_addr_error", int'(addr_error), 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    repeat (2) step();

    // T1: in-order logits, max 12 at index 2
    begin_run();
    write_vec(v1);
    wait_done(lat);
    check("t1_latency", lat, 10);
    check("t1_class", int'(pred_class), 2);
    check("t1_score", int'(pred_score), 12);
    check("t1_err",   int'(addr_error), 0);
    end_run();

    // T2: all negative, tie at -7 resolves to index 2
    begin_run();
    write_vec(v2);
    wait_done(lat);
    check("t2_class", int'(pred_class), 2);
    check("t2_score", int'(pred_score), -7);
    end_run();

    // T3: out of order, address 3 written 20 then 1; max 10 at 4 and 7
    begin_run();
    wr(9, 6); wr(0, 4); wr(5, 3); wr(3, 20); wr(1, 8); wr(2, -2);
    wr(3, 1); wr(4, 10); wr(6, 9); wr(7, 10);
    check("t3_not_early", int'(done), 0);
    wr(8, 0);
    wait_done(lat);
    check("t3_latency", lat, 10);
    check("t3_class", int'(pred_class), 4);
    check("t3_score", int'(pred_score), 10);
    end_run();

    // T4: out-of-range address mid-stream
    begin_run();
    for (int i = 0; i < 5; i++) wr(i, v1[i]);
    wr(12, 999);
    for (int i = 5; i < N; i++) wr(i, v1[i]);
    wait_done(lat);
    check("t4_err",   int'(addr_error), 1);
    check("t4_class", int'(pred_class), 2);
    check("t4_score", int'(pred_score), 12);
    end_run();
    begin_run();
    check("t4_err_cleared", int'(addr_error), 0);

    // T5: abort after 4 writes, prior result kept
    for (int i = 0; i < 4; i++) wr(i, 1000 + i);
    start = 1'b0;
    repeat (15) step();
    check("t5_no_done", int'(done),       0);
    check("t5_class",   int'(pred_class), 2);
    check("t5_score",   int'(pred_score), 12);
    // async reset while resolving
    begin_run();
    write_vec(v1);
    repeat (3) step();
    #1 rst = 1'b1;
    start = 1'b0;
    #1;
    check("t5_rst_done",  int'(done),       0);
    check("t5_rst_class", int'(pred_class), 0);
    check("t5_rst_score", int'(pred_score), 0);
    check("t5_rst_err",   int'(addr_error), 0);
    rst = 1'b0;
    repeat (2) step();

    // T6: back-to-back runs
    begin_run();
    write_vec(va);
    wait_done(lat);
    check("t6a_class", int'(pred_class), 0);
    check("t6a_score", int'(pred_score), 3);
    step(); step();
    check("t6_done_held", int'(done), 1);
    start = 1'b0;
    step();
    check("t6_done_low", int'(done), 0);
    begin_run();
    write_vec(vb);
    wait_done(lat);
    check("t6b_class", int'(pred_class), 8);
    check("t6b_score", int'(pred_score), 9);
    end_run();

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < N; i++) begin
        vr[i]  = rval(mode);
        ord[i] = i;
      end
      for (int i = N - 1; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
      if ($urandom_range(0, 3) == 0) wr(int'($urandom_range(0, 15)), rval(0));
      abort = ($urandom_range(0, 7) == 0);
      begin_run();
      for (int k = 0; k < N; k++) begin
        if (abort && k == 4) break;
        if ($urandom_range(0, 3) == 0) step();
        if ($urandom_range(0, 5) == 0) wr(10 + int'($urandom_range(0, 5)), rval(0));
        if (k > 0 && $urandom_range(0, 5) == 0)
          wr(ord[int'($urandom_range(0, k - 1))], rval(mode));
        wr(ord[k], vr[ord[k]]);
      end
      if (abort) begin
        start = 1'b0;
        repeat (3) step();
      end else begin
        wait_done(lat);
        check("rand_latency", lat, 10);
        repeat (int'($urandom_range(0, 2))) step();
        start = 1'b0;
        repeat (int'($urandom_range(1, 2))) step();
      end
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
